// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse burst sequencer.
//   - seq_state_e : sequencer FSM states (IDLE, HIGH, LOW, DONE)
//   - DEF_CNT_W   : default width of the pulse count (max 15 pulses)
//   - DEF_WID_W   : default width of a phase length (max 15 cycles)
//   - eff_width() : maps a programmed length of 0 onto 1 so that every
//                   phase lasts at least one cycle
package pulse_seq_pkg;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_WID_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // Width-agnostic so that any parameterisation of the sequencer can use it;
  // callers zero-extend their operand and truncate the result back.
  function automatic int unsigned eff_width(input int unsigned x);
    return (x == 0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter used as the phase timer of the burst sequencer.
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset (count -> 0)
//   load     : load load_val on the next edge (has priority over en)
//   en       : decrement on the next edge; holds at zero, never wraps
//   load_val : value to load
//   zero     : high while the count is zero
module phase_counter #(
  parameter int WID_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [WID_W-1:0] load_val,
  output logic             zero
);

  logic [WID_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WID_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_burst_sequencer.sv
// Sequences a burst of burst_len pulses on one output line. Each pulse is
// eff(high_w) cycles high followed by eff(low_w) cycles low; a one-cycle
// done strobe follows the last low phase. Configuration is captured when a
// burst is accepted and is immune to input changes during the burst.
// Ports:
//   clock     : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   start     : burst request, only honoured in IDLE
//   burst_len : number of pulses (0 -> straight to done, no pulse)
//   high_w    : high-phase length in cycles (0 treated as 1)
//   low_w     : low-phase length in cycles (0 treated as 1)
//   abort     : terminate a running burst without a done strobe
//   pulse     : registered pulse train
//   busy      : high while a burst is running
//   done      : one-cycle completion strobe
module pulse_burst_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WID_W = DEF_WID_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [WID_W-1:0] high_w,
  input  logic [WID_W-1:0] low_w,
  input  logic             abort,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  seq_state_e       state, next_state;
  logic [CNT_W-1:0] pulse_cnt;
  logic [WID_W-1:0] high_cfg;
  logic [WID_W-1:0] low_cfg;

  logic             capture;
  logic             pulse_dec;
  logic             ph_load;
  logic             ph_en;
  logic [WID_W-1:0] ph_val;
  logic             ph_zero;

  // Phase counter reload value: a phase of eff(w) cycles counts eff(w)-1..0.
  function automatic logic [WID_W-1:0] phase_init(input logic [WID_W-1:0] w);
    return WID_W'(eff_width(32'(w)) - 32'd1);
  endfunction

  phase_counter #(
    .WID_W (WID_W)
  ) u_phase (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (ph_load),
    .en       (ph_en),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    pulse_dec  = 1'b0;
    ph_load    = 1'b0;
    ph_en      = 1'b0;
    ph_val     = '0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            capture    = 1'b1;
            ph_load    = 1'b1;
            ph_val     = phase_init(high_w);
            next_state = ST_HIGH;
          end else begin
            next_state = ST_DONE;
          end
        end
      end
      ST_HIGH: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (ph_zero) begin
          ph_load    = 1'b1;
          ph_val     = phase_init(low_cfg);
          next_state = ST_LOW;
        end else begin
          ph_en = 1'b1;
        end
      end
      ST_LOW: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (ph_zero) begin
          pulse_dec = 1'b1;
          // pulse_cnt is the count before this decrement; 1 means last pulse.
          if (pulse_cnt <= CNT_W'(1)) begin
            next_state = ST_DONE;
          end else begin
            ph_load    = 1'b1;
            ph_val     = phase_init(high_cfg);
            next_state = ST_HIGH;
          end
        end else begin
          ph_en = 1'b1;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      pulse_cnt <= '0;
      high_cfg  <= '0;
      low_cfg   <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        pulse_cnt <= burst_len;
        high_cfg  <= high_w;
        low_cfg   <= low_w;
      end else if (pulse_dec && (pulse_cnt != '0)) begin
        pulse_cnt <= pulse_cnt - CNT_W'(1);
      end
    end
  end

  // Outputs decoded from next_state so they change on the same edge as the
  // state; pulse therefore rises on the edge that samples start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pulse <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      pulse <= (next_state == ST_HIGH);
      busy  <= (next_state == ST_HIGH) || (next_state == ST_LOW);
      done  <= (next_state == ST_DONE);
    end
  end

endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// Self-checking bench for pulse_burst_sequencer. A reference model expands
// each accepted burst into a queue of expected {pulse,busy,done} cycles.
module tb_pulse_burst_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] burst_len;
  logic [3:0] high_w;
  logic [3:0] low_w;
  logic       abort;
  logic       pulse;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] q[$];
  logic [2:0] cur;

  logic       r_s, r_ab;
  logic [3:0] r_len, r_h, r_l;
  logic [11:0] pv, dv;

  always #5 clock = ~clock;

  pulse_burst_sequencer #(
    .CNT_W (4),
    .WID_W (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .burst_len (burst_len),
    .high_w    (high_w),
    .low_w     (low_w),
    .abort     (abort),
    .pulse     (pulse),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned eff(input logic [3:0] w);
    return (w == 4'd0) ? 32'd1 : 32'(w);
  endfunction

  // Expected output of every cycle of one burst, then the done cycle.
  task automatic push_burst(input logic [3:0] len, input logic [3:0] h, input logic [3:0] l);
    if (len == 4'd0) begin
      q.push_back(3'b001);
    end else begin
      for (int p = 0; p < int'(len); p++) begin
        for (int i = 0; i < int'(eff(h)); i++) q.push_back(3'b110);
        for (int i = 0; i < int'(eff(l)); i++) q.push_back(3'b010);
      end
      q.push_back(3'b001);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic step(input string tag, input logic s, input logic [3:0] len,
                      input logic [3:0] h, input logic [3:0] l, input logic ab);
    logic [2:0] nxt;
    start     = s;
    burst_len = len;
    high_w    = h;
    low_w     = l;
    abort     = ab;
    if (cur == 3'b000 && s) push_burst(len, h, l);
    if (cur[1] && ab) q.delete();
    nxt = (q.size() > 0) ? q.pop_front() : 3'b000;
    @(posedge clock);
    #1;
    cur = nxt;
    chk(tag, 32'({pulse, busy, done}), 32'(nxt));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    cur       = 3'b000;
    reset_n   = 1'b0;
    start     = 1'b0;
    burst_len = 4'd0;
    high_w    = 4'd0;
    low_w     = 4'd0;
    abort     = 1'b0;
    #12;
    chk("reset_outs", 32'({pulse, busy, done}), 32'd0);
    reset_n = 1'b1;
    idle("post_reset", 2);

    // Basic burst: 3 pulses of 2 high / 2 low.
    step("basic", 1'b1, 4'd3, 4'd2, 4'd2, 1'b0);
    pv = {11'd0, pulse};
    for (int i = 0; i < 11; i++) begin
      step("basic", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      pv = {pv[10:0], pulse};
    end
    chk("basic_pulse", 32'(pv), 32'(12'b110011001100));
    chk("basic_busy", 32'(busy), 32'd1);
    step("basic_done", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("basic_done_lit", 32'({pulse, busy, done}), 32'(3'b001));
    step("basic_idle", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("basic_idle_lit", 32'({pulse, busy, done}), 32'd0);
    idle("gap", 2);

    // Zero widths.
    step("zero_w", 1'b1, 4'd2, 4'd0, 4'd0, 1'b0);
    pv = {11'd0, pulse};
    for (int i = 0; i < 3; i++) begin
      step("zero_w", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      pv = {pv[10:0], pulse};
    end
    chk("zero_w_pulse", 32'(pv[3:0]), 32'(4'b1010));
    step("zero_w_done", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("zero_w_done_lit", 32'(done), 32'd1);
    idle("gap", 2);

    // Zero count: done straight away.
    step("zero_len", 1'b1, 4'd0, 4'd5, 4'd5, 1'b0);
    chk("zero_len_lit", 32'({pulse, busy, done}), 32'(3'b001));
    idle("zero_len_after", 3);

    // Abort during the second high phase.
    step("abort", 1'b1, 4'd3, 4'd4, 4'd4, 1'b0);
    for (int i = 0; i < 9; i++) step("abort_run", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("abort_in_high", 32'(pulse), 32'd1);
    step("abort_hit", 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    chk("abort_lit", 32'({pulse, busy, done}), 32'd0);
    idle("abort_after", 6);
    step("abort_restart", 1'b1, 4'd1, 4'd1, 4'd1, 1'b0);
    idle("abort_restart", 4);

    // Start pulsed and config changed mid-burst.
    step("cfg", 1'b1, 4'd2, 4'd3, 4'd1, 1'b0);
    pv = {11'd0, pulse};
    for (int i = 0; i < 7; i++) begin
      step("cfg_run", i[0], 4'd7, 4'd1, 4'd0, 1'b0);
      pv = {pv[10:0], pulse};
    end
    chk("cfg_pulse", 32'(pv[7:0]), 32'(8'b11101110));
    step("cfg_done", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("cfg_done_lit", 32'(done), 32'd1);
    idle("gap", 2);

    // Asynchronous reset between edges while high.
    step("arst", 1'b1, 4'd3, 4'd4, 4'd4, 1'b0);
    step("arst_run", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_immediate", 32'({pulse, busy, done}), 32'd0);
    q.delete();
    cur = 3'b000;
    #2;
    reset_n = 1'b1;
    idle("arst_after", 5);

    // Back-to-back with start held.
    step("b2b", 1'b1, 4'd1, 4'd1, 4'd1, 1'b0);
    pv = {11'd0, pulse};
    dv = {11'd0, done};
    for (int i = 0; i < 11; i++) begin
      step("b2b", 1'b1, 4'd1, 4'd1, 4'd1, 1'b0);
      pv = {pv[10:0], pulse};
      dv = {dv[10:0], done};
    end
    chk("b2b_pulse", 32'(pv), 32'(12'b100010001000));
    chk("b2b_done", 32'(dv), 32'(12'b001000100010));
    idle("gap", 4);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r_s   = ($urandom_range(0, 3) == 0);
      r_len = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      r_h   = 4'($urandom_range(0, 4));
      r_l   = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      r_ab  = ($urandom_range(0, 59) == 0);
      step("rand", r_s, r_len, r_h, r_l, r_ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_burst_sequencer.md
Name: pulse_burst_sequencer

Overview:
- Synthesizable controller that sequences a burst of N pulses on one output line.
- High width, low width and pulse count are programmable and captured per burst.
- Replaces fixed-delay behavioural pulse trains in the lab designs with a clocked FSM plus counters.
- Handshake: start / busy / done. Accepts an abort request.
- Sits between a test or control master and any pulse-consuming block.

Parameters:
- CNT_W, 4: width of the burst_len input and the internal pulse counter (max 15 pulses).
- WID_W, 4: width of the high_w and low_w inputs and the phase counter (max 15 cycles per phase).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  burst request; sampled only in IDLE.
- burst_len  input  CNT_W  number of pulses in the burst; captured on start.
- high_w  input  WID_W  high-phase length in cycles; captured on start; 0 is treated as 1.
- low_w  input  WID_W  low-phase length in cycles; captured on start; 0 is treated as 1.
- abort  input  1  terminate the current burst.
- pulse  output  1  registered pulse train.
- busy  output  1  high while in HIGH or LOW.
- done  output  1  one-cycle completion strobe.

Behaviour:
- Reset (asynchronous, immediate, including mid-burst):
  - state = IDLE.
  - pulse = 0, busy = 0, done = 0.
  - All counters and captured config registers = 0.
- States: IDLE, HIGH, LOW, DONE. All outputs are registered and decoded from the next state.
  - pulse = 1 only in HIGH.
  - busy = 1 in HIGH and LOW.
  - done = 1 only in DONE.
- IDLE:
  - start=1 with burst_len≠0: capture config.
    - pulse counter ← burst_len.
    - phase counter ← eff(high_w) − 1, where eff(x) = (x==0) ? 1 : x.
    - Go to HIGH. pulse rises at that same edge, i.e. latency 0 cycles after the sampling edge.
  - start=1 with burst_len=0: go to DONE directly, no pulse.
- HIGH:
  - Phase counter decrements each cycle.
  - At 0: go to LOW and load eff(low_w) − 1.
  - pulse is high for exactly eff(high_w) cycles.
- LOW:
  - Phase counter decrements each cycle.
  - At 0: decrement the pulse counter.
    - Result ≠ 0: go to HIGH and reload eff(high_w) − 1.
    - Result = 0: go to DONE.
  - Every pulse, including the last, is followed by a full low phase.
- DONE: lasts exactly one cycle, then IDLE. start is ignored in DONE; a new burst is accepted at the earliest on the following cycle.
- start while busy: ignored. Captured config is unaffected by input changes mid-burst.
- abort while in HIGH or LOW:
  - Next edge: state = IDLE, pulse = 0, busy = 0.
  - done is NOT asserted.
- abort in DONE: no effect; done still pulses.
- abort in IDLE: ignored. abort and start together in IDLE means start is accepted.
- Counters never wrap: decrement happens only when nonzero; transitions are taken on zero.
- Total burst length in cycles = burst_len × (eff(high_w) + eff(low_w)). The DONE cycle follows.

Decomposition:
- Package pulse_seq_pkg holds:
  - state enum type (IDLE, HIGH, LOW, DONE);
  - default widths CNT_W and WID_W;
  - function eff_width (0→1 mapping).
- Sub-module phase_counter: loadable down-counter of WID_W bits with load, enable and zero flag. Instantiated once for the phase timer.
- The pulse counter stays inline in the sequencer.

Test Plan:
- Basic burst:
  - Stimulus: reset released; start=1 for one cycle with burst_len=3, high_w=2, low_w=2.
  - Response, cycles counted from the sampling edge: pulse = 1,1,0,0,1,1,0,0,1,1,0,0; busy = 1 for all 12 cycles; done = 1 on cycle 13; IDLE on cycle 14.
- Zero widths and zero count:
  - Stimulus A: burst_len=2, high_w=0, low_w=0.
  - Response A: pulse = 1,0,1,0, then done.
  - Stimulus B: burst_len=0.
  - Response B: done on the cycle after the sampling edge; pulse and busy never rise.
- Abort mid-burst:
  - Stimulus: burst_len=3, high_w=4, low_w=4; abort=1 during the 2nd HIGH (cycle 10).
  - Response: pulse = 0 and busy = 0 from the next edge; done never asserts; a following start begins a new burst normally.
- Start while busy and config change:
  - Stimulus: burst_len=2, high_w=3, low_w=1; pulse start high and set burst_len=7, high_w=1 mid-burst.
  - Response: output unchanged at 1,1,1,0,1,1,1,0; done after 8 cycles.
- Asynchronous reset mid-operation:
  - Stimulus: assert reset_n=0 between clock edges during HIGH.
  - Response: pulse, busy and done go to 0 immediately, without waiting for an edge; after release, no activity until start.
- Back-to-back bursts:
  - Stimulus: hold start=1 continuously with burst_len=1, high_w=1, low_w=1.
  - Response: repeating pattern pulse 1,0 with done on the 3rd cycle, then IDLE, a new burst from the 4th cycle. Period 4 cycles.
